pipe_stage_buffer: RTL and testbench

- Parametrised elastic pipeline-stage register. Replaces the fixed always-load stage registers between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, per-stage stall, flush with bubble injection, and DEPTH-entry buffering.
- One instance sits between each pair of adjacent pipeline stages. The payload is the concatenated stage bundle: pc, instr, control word, operands, immediates and rd.

---
 rtl/pipe_stage_buffer.sv | 87 ++++++++
 tb/tb_pipe_stage_buffer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with valid/ready handshake, flush and bubble output.
// Optional same-cycle bypass when empty is enabled by defining PIPE_STAGE_BUFFER_BYPASS_EN.
module pipe_stage_buffer #(
    parameter int          WIDTH  = 32,
    parameter int          DEPTH  = 2,
    parameter logic [31:0] BUBBLE = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       up_valid_i,
    output logic                       up_ready_o,
    input  logic [WIDTH-1:0]           up_data_i,
    output logic                       dn_valid_o,
    input  logic                       dn_ready_i,
    output logic [WIDTH-1:0]           dn_data_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    FULL     = CW'(DEPTH);
    localparam logic [PW-1:0]    LAST     = PW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             push, pop, bypass;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        bypass = 1'b0;
`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
        bypass = (count == '0) && up_valid_i && dn_ready_i;
`endif
        up_ready_o = (count != FULL);
        push       = up_valid_i && up_ready_o && !bypass;
        pop        = (count != '0) && dn_ready_i;
        dn_valid_o = (count != '0);
        dn_data_o  = dn_valid_o ? mem[rd_ptr] : BUBBLE_W;
`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
        // A bypassed payload is discarded like any other when flushed or reset.
        if (bypass && !flush_i && !rst) begin
            dn_valid_o = 1'b1;
            dn_data_o  = up_data_i;
        end
`endif
    end

    assign occupancy_o = count;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush_i) mem[wr_ptr] <= up_data_i;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= FULL);
            assert (!(pop && count == '0));
            assert (!(push && count == FULL));
            assert (!(up_valid_i && $isunknown(up_data_i)));
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: DEPTH=2 and DEPTH=3 instances share stimulus,
// each checked cycle by cycle against a queue-based model of the FIFO rules.
module tb_pipe_stage_buffer;
    localparam logic [31:0] BUB = 32'h00000013;
    localparam int          DEP [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0, flush = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
    logic [31:0] up_data = '0;
    logic        up_ready [2];
    logic        dn_valid [2];
    logic [31:0] dn_data  [2];
    logic [1:0]  occ2;
    logic [1:0]  occ3;

    int          errors = 0, checks = 0;
    logic        en = 1'b0;
    logic [31:0] exp_q [2][$];

    always #5 clk = ~clk;

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(2), .BUBBLE(BUB)) u2 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(up_ready[0]), .up_data_i(up_data),
        .dn_valid_o(dn_valid[0]), .dn_ready_i(dn_ready), .dn_data_o(dn_data[0]),
        .occupancy_o(occ2)
    );

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(3), .BUBBLE(BUB)) u3 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(up_ready[1]), .up_data_i(up_data),
        .dn_valid_o(dn_valid[1]), .dn_ready_i(dn_ready), .dn_data_o(dn_data[1]),
        .occupancy_o(occ3)
    );

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s depth=%0d t=%0t got=%h expected=%h", name, DEP[k], $time, got, exp);
        end
    endtask

    // Monitor/model: inputs are stable after the falling edge; outputs are checked well
    // before the next rising edge, then the model advances as that edge will.
    always @(negedge clk) begin
        #3;
        for (int k = 0; k < 2; k++) begin
            int          cnt;
            logic        byp, ev, acc;
            logic [31:0] ed, occ;
            cnt = exp_q[k].size();
            byp = 1'b0;
`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
            byp = (cnt == 0) && up_valid && dn_ready;
`endif
            ev  = (cnt != 0) || (byp && !flush && !rst);
            ed  = (cnt != 0) ? exp_q[k][0] : ((byp && !flush && !rst) ? up_data : BUB);
            occ = (k == 0) ? 32'(occ2) : 32'(occ3);
            if (en) begin
                check("dn_valid", k, 32'(dn_valid[k]), 32'(ev));
                check("dn_data", k, dn_data[k], ed);
                check("up_ready", k, 32'(up_ready[k]), 32'(cnt != DEP[k]));
                check("occupancy", k, occ, 32'(cnt));
            end
            if (rst || flush) begin
                exp_q[k].delete();
            end else begin
                acc = up_valid && (cnt != DEP[k]) && !byp;
                if (cnt != 0 && dn_ready) void'(exp_q[k].pop_front());
                if (acc) exp_q[k].push_back(up_data);
            end
        end
    end

    task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] d, input logic rd);
        @(negedge clk);
        rst = r; flush = f; up_valid = v; up_data = d; dn_ready = rd;
    endtask

    initial begin
        // Reset with a payload offered: nothing may be stored.
        cyc(1, 0, 1, 32'hDEAD, 1);
        cyc(1, 0, 1, 32'hBEEF, 0);
        en = 1'b1;
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 1);
        // Streaming with downstream always ready.
        cyc(0, 0, 1, 32'hA0, 1);
        cyc(0, 0, 1, 32'hA1, 1);
        cyc(0, 0, 1, 32'hA2, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        // Stall until full, release, then re-offer the refused payload.
        cyc(0, 0, 1, 32'h11, 0);
        cyc(0, 0, 1, 32'h22, 0);
        cyc(0, 0, 1, 32'h33, 0);
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 1, 32'h33, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 1);
        // Fill, then push and pop together while full.
        cyc(0, 0, 1, 32'h40, 0);
        cyc(0, 0, 1, 32'h41, 0);
        cyc(0, 0, 1, 32'h42, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h50 + i, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 1);
        // Ten push/pop pairs exercise pointer wrap on both depths.
        cyc(0, 0, 1, 32'h0FF, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 32'h100 + i, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 32'h0, 1);
        // Flush with two entries held and a push offered.
        cyc(0, 0, 1, 32'h61, 0);
        cyc(0, 0, 1, 32'h62, 0);
        cyc(0, 1, 1, 32'h55, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        // Empty buffer, downstream ready: bypass or one-cycle latency.
        cyc(0, 0, 1, 32'h77, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 3),
                ($urandom_range(0, 99) < 70), $urandom, ($urandom_range(0, 99) < 60));
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
